// File: rtl/note_edge_detect.sv
// note_edge_detect: per-channel debounced level with an edge-selected one-cycle pulse and a sticky event flag.
// Define NOTE_EDGE_SYNC_EN to place a two-flop synchroniser ahead of each debouncer.
module note_edge_detect #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                r,
    input  logic [CHANNELS-1:0] in,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] clr,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] sticky,
    output logic                any
);

    localparam int unsigned      CNT_W     = 8;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [1:0]       MODE_RISE = 2'b00;
    localparam logic [1:0]       MODE_FALL = 2'b01;
    localparam logic [1:0]       MODE_BOTH = 2'b10;

    logic [CHANNELS-1:0] s;

`ifdef NOTE_EDGE_SYNC_EN
    logic [CHANNELS-1:0] meta;

    // Two-flop synchroniser; s is the second stage.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            meta <= '0;
            s    <= '0;
        end else begin
            meta <= in;
            s    <= meta;
        end
    end
`else
    // Single sample stage for inputs already in the clk domain.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            s <= '0;
        end else begin
            s <= in;
        end
    end
`endif

    logic [CNT_W-1:0]    cnt     [CHANNELS];
    logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] flip;
    logic [CHANNELS-1:0] level_nxt;
    logic [CHANNELS-1:0] pulse_nxt;
    logic [CHANNELS-1:0] sticky_nxt;

    // Debounce: count consecutive samples that disagree with level, flip on the last one.
    always_comb begin
        flip      = '0;
        level_nxt = level;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_nxt[i] = '0;
            if (s[i] != level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    flip[i]      = 1'b1;
                    level_nxt[i] = s[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge select; the new level tells which direction the flip went.
    always_comb begin
        pulse_nxt = '0;
        case (mode)
            MODE_RISE: pulse_nxt = flip & level_nxt;
            MODE_FALL: pulse_nxt = flip & ~level_nxt;
            MODE_BOTH: pulse_nxt = flip;
            default:   pulse_nxt = '0;
        endcase
    end

    // A registered pulse sets the flag even when clear is asserted on the same edge.
    always_comb begin
        sticky_nxt = pulse | (sticky & ~clr);
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            level  <= '0;
            pulse  <= '0;
            sticky <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            level  <= level_nxt;
            pulse  <= pulse_nxt;
            sticky <= sticky_nxt;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign any = |pulse;

endmodule

// File: tb/tb_note_edge_detect.sv
// Self-checking bench for note_edge_detect: directed scenarios plus randomized traffic,
// all compared every cycle against a window-based reference model.
module tb_note_edge_detect;

    localparam int unsigned CH   = 4;
    localparam int          D    = 4;
`ifdef NOTE_EDGE_SYNC_EN
    localparam int          S    = 2;
`else
    localparam int          S    = 1;
`endif
    localparam int          MAXE = 8192;

    logic          clk = 1'b0;
    logic          r;
    logic [CH-1:0] din;
    logic [1:0]    mode;
    logic [CH-1:0] clr;
    logic [CH-1:0] level;
    logic [CH-1:0] pulse;
    logic [CH-1:0] sticky;
    logic          any_o;

    note_edge_detect #(.CHANNELS(CH), .DEBOUNCE(D)) dut (
        .clk(clk), .r(r), .in(din), .mode(mode), .clr(clr),
        .level(level), .pulse(pulse), .sticky(sticky), .any(any_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sample history per edge; a flip happens when the last D samples
    // (all after the previous flip/reset) disagree with the current level.
    logic [CH-1:0] in_at [MAXE];
    logic [CH-1:0] s_at  [MAXE];
    int            k = 0;
    int            last_flip [CH];
    logic [CH-1:0] m_level = '0;
    logic [CH-1:0] m_pulse = '0;
    logic [CH-1:0] m_sticky = '0;

    function automatic logic edge_hit(input logic [1:0] md, input logic new_lvl);
        case (md)
            2'd0:    return new_lvl;
            2'd1:    return !new_lvl;
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        logic [CH-1:0] new_level;
        logic [CH-1:0] new_pulse;
        logic          fl;
        if (k >= MAXE) begin
            $display("FAIL model_overflow got=%0d exp<%0d", k, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        if (r) begin
            in_at[k] = '0;
            s_at[k]  = '0;
            m_level  = '0;
            m_pulse  = '0;
            m_sticky = '0;
            for (int i = 0; i < int'(CH); i++) last_flip[i] = k;
        end else begin
            in_at[k]  = din;
            s_at[k]   = (k >= S) ? in_at[k-S] : '0;
            new_level = m_level;
            new_pulse = '0;
            for (int i = 0; i < int'(CH); i++) begin
                fl = 1'b1;
                for (int j = k - D + 1; j <= k; j++) begin
                    if (j < 0 || j <= last_flip[i]) fl = 1'b0;
                    else if (s_at[j][i] == m_level[i]) fl = 1'b0;
                end
                if (fl) begin
                    new_level[i] = ~m_level[i];
                    last_flip[i] = k;
                    new_pulse[i] = edge_hit(mode, new_level[i]);
                end
            end
            m_sticky = m_pulse | (m_sticky & ~clr);
            m_pulse  = new_pulse;
            m_level  = new_level;
        end
        k++;
    endtask

    int            pcnt [CH];
    int            tcnt [CH];
    logic [CH-1:0] prev_level = '0;

    task automatic clear_counts();
        for (int i = 0; i < int'(CH); i++) begin
            pcnt[i] = 0;
            tcnt[i] = 0;
        end
    endtask

    // One clock: model update at the edge, compare just after, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("level",  32'(level),  32'(m_level));
        check_eq("pulse",  32'(pulse),  32'(m_pulse));
        check_eq("sticky", 32'(sticky), 32'(m_sticky));
        check_eq("any",    32'(any_o),  32'(|m_pulse));
        for (int i = 0; i < int'(CH); i++) begin
            pcnt[i] += int'(pulse[i]);
            if (level[i] != prev_level[i]) tcnt[i]++;
        end
        prev_level = level;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int pulse_at;
        bit found;
        int exp_p [4];
        int rst_left;
        exp_p = '{3, 3, 6, 0};

        // Reset held with all inputs high.
        r = 1'b1; din = '1; mode = 2'b00; clr = '0;
        clear_counts();
        repeat (3) tick();
        check_eq("rst_out", 32'({level, pulse, sticky, any_o}), 32'(0));

        // Release: inputs already high look like a rising transition.
        r = 1'b0;
        n = 0;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            tick();
            n++;
            if (pulse == '1) found = 1'b1;
        end
        check_eq("rel_latency", 32'(n), 32'(S + D));
        tick();
        check_eq("rel_sticky", 32'(sticky), 32'({CH{1'b1}}));
        check_eq("rel_pulse_once", 32'(pulse), 32'(0));

        din = '0; clr = '1;
        repeat (12) tick();
        clr = '0;

        // Glitch filtering on ch0.
        clear_counts();
        repeat (6) begin
            din[0] = 1'b1; tick();
            din[0] = 1'b0; tick(); tick();
        end
        check_eq("glitch_pulses", 32'(pcnt[0]), 32'(0));
        check_eq("glitch_toggles", 32'(tcnt[0]), 32'(0));

        clear_counts();
        din[0] = 1'b1;
        pulse_at = -1;
        n = 0;
        for (int t = 0; t < 16; t++) begin
            if (t == 6) din[0] = 1'b0;
            tick();
            n++;
            if (pulse[0] && pulse_at < 0) pulse_at = n;
        end
        check_eq("ch0_latency", 32'(pulse_at), 32'(S + D));
        check_eq("ch0_one_pulse", 32'(pcnt[0]), 32'(1));

        // Edge modes on ch1, square wave of period 20.
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            clear_counts();
            repeat (3) begin
                din[1] = 1'b1; repeat (10) tick();
                din[1] = 1'b0; repeat (10) tick();
            end
            check_eq($sformatf("mode%0d_pulses", m), 32'(pcnt[1]), 32'(exp_p[m]));
            check_eq($sformatf("mode%0d_toggles", m), 32'(tcnt[1]), 32'(6));
        end

        // Sticky set-wins on ch2.
        mode = 2'b00; clr = '1; tick();
        clr = 4'b0100;
        din[2] = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            tick();
            if (pulse[2]) found = 1'b1;
        end
        check_eq("ch2_pulse_seen", 32'(found), 32'(1));
        tick();
        check_eq("sticky_set_wins", 32'(sticky[2]), 32'(1));
        tick();
        check_eq("sticky_cleared", 32'(sticky[2]), 32'(0));
        din[2] = 1'b0;
        repeat (10) tick();
        clr = '0;
        din[2] = 1'b1;
        repeat (16) tick();
        check_eq("sticky_hold", 32'(sticky[2]), 32'(1));
        din[2] = 1'b0;
        repeat (10) tick();

        // Reset two counts into a debounce on ch3.
        din[3] = 1'b1;
        repeat (S + 2) tick();
        r = 1'b1; din[3] = 1'b0;
        repeat (3) tick();
        r = 1'b0;
        clear_counts();
        repeat (20) tick();
        check_eq("abort_pulses", 32'(pcnt[3]), 32'(0));
        check_eq("abort_level", 32'(level[3]), 32'(0));

        // Randomized traffic.
        rst_left = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < int'(CH); i++)
                if ($urandom_range(5) == 0) din[i] = ~din[i];
            if ($urandom_range(49) == 0) mode = 2'($urandom);
            clr = CH'($urandom & $urandom);
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(399) == 0) rst_left = 3;
            r = (rst_left > 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
